// File: rtl/sata_oob_pkg.sv
// sata_oob_pkg: shared state encoding, timer width and default timing
// constants for the SATA OOB controller.
package sata_oob_pkg;

  localparam int TMR_W = 20;

  // 400000 cycles per COMINIT/COMWAKE wait, 880000 cycles to see ALIGN.
  localparam logic [TMR_W-1:0] C_TIMEOUT_DEF       = 20'd400000;
  localparam logic [TMR_W-1:0] C_ALIGN_TIMEOUT_DEF = 20'd880000;
  localparam logic [3:0]       C_MAX_RETRY_DEF     = 4'd8;
  localparam logic [3:0]       C_RETRY_SAT         = 4'hF;

  // The third non-ALIGN cycle in SEND_ALIGN arrives with the run counter at 2.
  localparam logic [1:0]       C_RUN_LAST          = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_COMRESET       = 4'd1,
    ST_WAIT_COMINIT   = 4'd2,
    ST_WAIT_NOCOMINIT = 4'd3,
    ST_COMWAKE        = 4'd4,
    ST_WAIT_COMWAKE   = 4'd5,
    ST_WAIT_NOCOMWAKE = 4'd6,
    ST_WAIT_ALIGN     = 4'd7,
    ST_SEND_ALIGN     = 4'd8,
    ST_LINK_UP        = 4'd9,
    ST_ERROR          = 4'd10
  } oob_state_e;

  // Retry counter increment that sticks at all-ones.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == C_RETRY_SAT) ? v : v + 4'd1;
  endfunction

  // States in which the transmitter drives data instead of electrical idle.
  function automatic logic tx_active(input oob_state_e s);
    return (s == ST_WAIT_ALIGN) || (s == ST_SEND_ALIGN) || (s == ST_LINK_UP);
  endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// sata_oob_timer: loadable down-counter that stops at zero.
// The zero flag is decoded from the registered count, so a load takes one
// cycle before the flag can reflect the new value.
module sata_oob_timer
  import sata_oob_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);

  localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear beats load, otherwise decrement and hold at zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - C_ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sata_oob_ctrl.sv
// sata_oob_ctrl: host-side SATA out-of-band sequencer (COMRESET, COMINIT,
// COMWAKE, ALIGN exchange) ending in link-up.
// Optional build macro SATA_OOB_RETRY_LIMIT_EN: after P_MAX_RETRY timeouts
// without a link-up the controller locks into ERROR until i_reset. Without
// the macro it retries forever and o_err only pulses.
//
// state          | meaning
// ---------------+-------------------------------------------------------
// IDLE           | waiting for the PHY to become usable
// COMRESET       | transmitting COMRESET bursts
// WAIT_COMINIT   | waiting for the device COMINIT (timed)
// WAIT_NOCOMINIT | waiting for the COMINIT bursts to end
// COMWAKE        | transmitting COMWAKE bursts
// WAIT_COMWAKE   | waiting for the device COMWAKE (timed)
// WAIT_NOCOMWAKE | waiting for COMWAKE to end and the line to go active
// WAIT_ALIGN     | sending D10.2, waiting for a device ALIGN (timed)
// SEND_ALIGN     | sending ALIGN until three non-ALIGN cycles in a row
// LINK_UP        | link established
// ERROR          | retry limit exhausted, held until reset
module sata_oob_ctrl
  import sata_oob_pkg::*;
#(
  parameter logic [TMR_W-1:0] P_TIMEOUT       = C_TIMEOUT_DEF,
  parameter logic [TMR_W-1:0] P_ALIGN_TIMEOUT = C_ALIGN_TIMEOUT_DEF,
  parameter logic [3:0]       P_MAX_RETRY     = C_MAX_RETRY_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_phy_ready,
  input  logic i_rx_cominit,
  input  logic i_rx_comwake,
  input  logic i_rx_elecidle,
  input  logic i_rx_align,
  input  logic i_tx_comfinish,
  output logic o_tx_comreset,
  output logic o_tx_comwake,
  output logic o_tx_elecidle,
  output logic o_tx_align,
  output logic o_link_up,
  output logic o_err
);

  // A zero retry limit would lock out on the very first timeout.
  if (P_MAX_RETRY == 4'd0) begin : g_bad_retry
    $error("sata_oob_ctrl: P_MAX_RETRY must be nonzero");
  end

  oob_state_e       state_q;
  oob_state_e       state_d;
  logic [3:0]       retry_q;
  logic [3:0]       retry_d;
  logic [1:0]       run_q;
  logic [1:0]       run_d;
  logic             err_d;
  logic             timeout;

  logic             tmr_clear;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_zero;

  logic             tx_comreset_q;
  logic             tx_comwake_q;
  logic             tx_elecidle_q;
  logic             tx_align_q;
  logic             link_up_q;
  logic             err_q;

  sata_oob_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .clear_i (tmr_clear),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  // Next-state, retry/run counters and timer control.
  // In the timed waits the device event is tested before the timer, so an
  // event arriving in the same cycle the timer reads zero still advances.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    run_d     = run_q;
    err_d     = 1'b0;
    timeout   = 1'b0;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = P_TIMEOUT;

    if (!i_phy_ready && (state_q != ST_ERROR)) begin
      state_d   = ST_IDLE;
      retry_d   = 4'd0;
      run_d     = 2'd0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COMRESET;
        end
        ST_COMRESET: begin
          if (i_tx_comfinish) begin
            state_d   = ST_WAIT_COMINIT;
            tmr_load  = 1'b1;
            tmr_value = P_TIMEOUT;
          end
        end
        ST_WAIT_COMINIT: begin
          if (i_rx_cominit) begin
            state_d = ST_WAIT_NOCOMINIT;
          end else if (tmr_zero) begin
            timeout = 1'b1;
          end
        end
        ST_WAIT_NOCOMINIT: begin
          if (!i_rx_cominit) begin
            state_d = ST_COMWAKE;
          end
        end
        ST_COMWAKE: begin
          if (i_tx_comfinish) begin
            state_d   = ST_WAIT_COMWAKE;
            tmr_load  = 1'b1;
            tmr_value = P_TIMEOUT;
          end
        end
        ST_WAIT_COMWAKE: begin
          if (i_rx_comwake) begin
            state_d = ST_WAIT_NOCOMWAKE;
          end else if (tmr_zero) begin
            timeout = 1'b1;
          end
        end
        ST_WAIT_NOCOMWAKE: begin
          if (!i_rx_comwake && !i_rx_elecidle) begin
            state_d   = ST_WAIT_ALIGN;
            tmr_load  = 1'b1;
            tmr_value = P_ALIGN_TIMEOUT;
          end
        end
        ST_WAIT_ALIGN: begin
          if (i_rx_align) begin
            state_d = ST_SEND_ALIGN;
            run_d   = 2'd0;
          end else if (tmr_zero) begin
            timeout = 1'b1;
          end
        end
        ST_SEND_ALIGN: begin
          if (i_rx_align) begin
            run_d = 2'd0;
          end else if (run_q == C_RUN_LAST) begin
            state_d = ST_LINK_UP;
            run_d   = 2'd0;
          end else begin
            run_d = run_q + 2'd1;
          end
        end
        ST_LINK_UP: begin
          retry_d = 4'd0;
          if (i_rx_cominit) begin
            state_d = ST_WAIT_NOCOMINIT;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (timeout) begin
        err_d   = 1'b1;
        retry_d = sat_inc4(retry_q);
        state_d = ST_COMRESET;
`ifdef SATA_OOB_RETRY_LIMIT_EN
        if (sat_inc4(retry_q) >= P_MAX_RETRY) begin
          state_d = ST_ERROR;
        end
`endif
      end
    end

`ifdef SATA_OOB_RETRY_LIMIT_EN
    if (state_d == ST_ERROR) begin
      err_d = 1'b1;
    end
`endif
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_IDLE;
      retry_q       <= 4'd0;
      run_q         <= 2'd0;
      tx_comreset_q <= 1'b0;
      tx_comwake_q  <= 1'b0;
      tx_elecidle_q <= 1'b1;
      tx_align_q    <= 1'b0;
      link_up_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      run_q         <= run_d;
      tx_comreset_q <= (state_d == ST_COMRESET);
      tx_comwake_q  <= (state_d == ST_COMWAKE);
      tx_elecidle_q <= !tx_active(state_d);
      tx_align_q    <= (state_d == ST_SEND_ALIGN);
      link_up_q     <= (state_d == ST_LINK_UP);
      err_q         <= err_d;
    end
  end

  assign o_tx_comreset = tx_comreset_q;
  assign o_tx_comwake  = tx_comwake_q;
  assign o_tx_elecidle = tx_elecidle_q;
  assign o_tx_align    = tx_align_q;
  assign o_link_up     = link_up_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_sata_oob_ctrl.sv
// tb_sata_oob_ctrl: randomized device-side handshakes for sata_oob_ctrl.
// Expected outcomes come from the link rules in timing terms: an event seen
// no later than limit+1 cycles after a wait is entered is accepted, otherwise
// o_err fires limit+1 cycles after entry; link-up follows the first run of
// three non-ALIGN cycles. Inputs are driven and outputs sampled on negedge.
module tb_sata_oob_ctrl;

  localparam int TO   = 100;
  localparam int ATO  = 200;
  localparam int MAXR = 3;
  localparam int EV_CI = 0;
  localparam int EV_CW = 1;
  localparam int EV_AL = 2;

  logic clk = 1'b0;
  logic rst;
  logic phy_ready;
  logic rx_cominit;
  logic rx_comwake;
  logic rx_elecidle;
  logic rx_align;
  logic tx_comfinish;
  logic tx_comreset;
  logic tx_comwake;
  logic tx_elecidle;
  logic tx_align;
  logic link_up;
  logic err;

  int n_checks = 0;
  int n_errs   = 0;
  int model_retry = 0;

  always #5 clk = ~clk;

  sata_oob_ctrl #(
    .P_TIMEOUT       (20'd100),
    .P_ALIGN_TIMEOUT (20'd200),
    .P_MAX_RETRY     (4'd3)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_phy_ready    (phy_ready),
    .i_rx_cominit   (rx_cominit),
    .i_rx_comwake   (rx_comwake),
    .i_rx_elecidle  (rx_elecidle),
    .i_rx_align     (rx_align),
    .i_tx_comfinish (tx_comfinish),
    .o_tx_comreset  (tx_comreset),
    .o_tx_comwake   (tx_comwake),
    .o_tx_elecidle  (tx_elecidle),
    .o_tx_align     (tx_align),
    .o_link_up      (link_up),
    .o_err          (err)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_ev(input int sel, input logic v);
    case (sel)
      EV_CI:   rx_cominit = v;
      EV_CW:   rx_comwake = v;
      default: rx_align   = v;
    endcase
  endtask

  function automatic bit locked_out();
`ifdef SATA_OOB_RETRY_LIMIT_EN
    return model_retry >= MAXR;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int pick(input int limit);
    int r;
    r = int'($urandom_range(0, 3));
    if (r == 0) return 1;
    if (r == 1) return limit + 1;
    return int'($urandom_range(1, limit + 1));
  endfunction

  function automatic logic req_out(input int which);
    return (which == 0) ? tx_comreset : tx_comwake;
  endfunction

  // Request is asserted now; answer with comfinish after dcf cycles.
  task automatic serve_req(input int which, input int dcf);
    check_val(which == 0 ? "req_comreset" : "req_comwake", req_out(which), 1'b1);
    repeat (dcf) begin
      tick();
      check_val("req_no_err", err, 1'b0);
      check_val("req_hold", req_out(which), 1'b1);
    end
    tx_comfinish = 1'b1;
    tick();
    tx_comfinish = 1'b0;
    check_val("req_drop", req_out(which), 1'b0);
  endtask

  // Called on the entry cycle of a timed wait; event seen j cycles later.
  task automatic wait_phase(input int sel, input int j, input int limit, output bit ok);
    bit done;
    done = 1'b0;
    ok   = 1'b0;
    for (int t = 1; t <= limit + 1 && !done; t++) begin
      if (t == j) set_ev(sel, 1'b1);
      tick();
      if (t == j) begin
        check_val("event_no_err", err, 1'b0);
        ok   = 1'b1;
        done = 1'b1;
      end else if (t == limit + 1) begin
        model_retry = (model_retry < 15) ? model_retry + 1 : 15;
        check_val("timeout_err", err, 1'b1);
        check_val("timeout_comreset", tx_comreset, locked_out() ? 1'b0 : 1'b1);
        done = 1'b1;
      end else begin
        check_val("wait_no_err", err, 1'b0);
      end
    end
  endtask

  // COMINIT is high and being waited out; w cycles high in total.
  task automatic cominit_tail(input int w);
    repeat (w - 1) begin
      tick();
      check_val("comwake_not_yet", tx_comwake, 1'b0);
    end
    rx_cominit = 1'b0;
    tick();
    check_val("comwake_after_cominit", tx_comwake, 1'b1);
  endtask

  task automatic align_run(input bit noise);
    int run;
    int n;
    bit up;
    logic b;
    run = 0;
    n   = 0;
    up  = 1'b0;
    while (!up) begin
      b = (noise && n < 24) ? ($urandom_range(0, 9) < 4) : 1'b0;
      rx_align = b;
      tick();
      n++;
      run = b ? 0 : run + 1;
      up  = (run >= 3);
      check_val("link_up_model", link_up, up);
      if (!up) check_val("tx_align_on", tx_align, 1'b1);
    end
    rx_align = 1'b0;
    check_val("link_tx_active", tx_elecidle, 1'b0);
    model_retry = 0;
  endtask

  task automatic handshake(input bit from_wake, input int dcf, input int j1, input int w1,
                           input int j2, input int w2, input int ei, input int j3,
                           input bit noise, input bit drop_in_send, output bit ok);
    ok = 1'b1;
    rx_elecidle = 1'b1;
    rx_align    = 1'b0;
    if (!from_wake) begin
      serve_req(0, dcf);
      wait_phase(EV_CI, j1, TO, ok);
      if (!ok) return;
      cominit_tail(w1);
    end
    serve_req(1, dcf);
    wait_phase(EV_CW, j2, TO, ok);
    if (!ok) return;
    repeat (w2 - 1) begin
      tick();
      check_val("nocomwake_idle", tx_elecidle, 1'b1);
    end
    rx_comwake = 1'b0;
    repeat (ei) begin
      tick();
      check_val("elecidle_hold", tx_elecidle, 1'b1);
    end
    rx_elecidle = 1'b0;
    tick();
    check_val("align_wait_tx_on", tx_elecidle, 1'b0);
    check_val("align_wait_no_align", tx_align, 1'b0);
    wait_phase(EV_AL, j3, ATO, ok);
    if (!ok) return;
    check_val("send_align_on", tx_align, 1'b1);
    if (drop_in_send) begin
      rx_align  = 1'b0;
      phy_ready = 1'b0;
      tick();
      check_val("drop_align_off", tx_align, 1'b0);
      check_val("drop_elecidle", tx_elecidle, 1'b1);
      check_val("drop_no_link", link_up, 1'b0);
      model_retry = 0;
      phy_ready = 1'b1;
      tick();
      check_val("drop_restart", tx_comreset, 1'b1);
    end else begin
      align_run(noise);
    end
  endtask

  task automatic rand_handshake(input bit from_wake, input int fault, output bit ok);
    handshake(from_wake, int'($urandom_range(1, 4)),
              (fault == 1) ? TO + 2 : pick(TO), int'($urandom_range(1, 4)),
              (fault == 2) ? TO + 2 : pick(TO), int'($urandom_range(1, 3)),
              int'($urandom_range(0, 3)),
              (fault == 3) ? ATO + 2 : pick(ATO), 1'b1, 1'b0, ok);
  endtask

  task automatic phy_cycle();
    phy_ready    = 1'b0;
    rx_cominit   = 1'b0;
    rx_comwake   = 1'b0;
    rx_align     = 1'b0;
    rx_elecidle  = 1'b1;
    tx_comfinish = 1'b0;
    tick();
    check_val("phy_off_elecidle", tx_elecidle, 1'b1);
    check_val("phy_off_comreset", tx_comreset, 1'b0);
    check_val("phy_off_link", link_up, 1'b0);
    check_val("phy_off_align", tx_align, 1'b0);
    check_val("phy_off_err", err, 1'b0);
    model_retry = 0;
    phy_ready = 1'b1;
    tick();
    check_val("phy_on_comreset", tx_comreset, 1'b1);
  endtask

  initial begin
    bit ok;
    rst          = 1'b1;
    phy_ready    = 1'b1;
    rx_cominit   = 1'b0;
    rx_comwake   = 1'b0;
    rx_elecidle  = 1'b1;
    rx_align     = 1'b0;
    tx_comfinish = 1'b0;
    repeat (3) tick();
    check_val("rst_comreset", tx_comreset, 1'b0);
    check_val("rst_comwake", tx_comwake, 1'b0);
    check_val("rst_elecidle", tx_elecidle, 1'b1);
    check_val("rst_align", tx_align, 1'b0);
    check_val("rst_link", link_up, 1'b0);
    check_val("rst_err", err, 1'b0);
    rst = 1'b0;
    tick();

    // Nominal bring-up with fixed response times.
    handshake(1'b0, 2, 50, 2, 30, 2, 0, 20, 1'b0, 1'b0, ok);

    // Device-initiated reset while linked.
    rx_cominit = 1'b1;
    tick();
    check_val("devreset_link_down", link_up, 1'b0);
    cominit_tail(3);
    handshake(1'b1, 2, 0, 0, 40, 1, 2, 60, 1'b1, 1'b0, ok);

    // Silent device: timeout in WAIT_COMINIT, then a retry whose COMINIT
    // coincides with the timer reaching zero.
    phy_cycle();
    handshake(1'b0, 2, TO + 2, 1, 30, 1, 0, 20, 1'b0, 1'b0, ok);
    handshake(1'b0, 2, TO + 1, 2, TO + 1, 2, 1, ATO + 1, 1'b0, 1'b0, ok);

    // Timeouts in the COMWAKE and ALIGN waits.
    phy_cycle();
    handshake(1'b0, 1, 10, 1, TO + 2, 1, 0, 20, 1'b0, 1'b0, ok);
    handshake(1'b0, 1, 10, 1, 10, 1, 0, 20, 1'b0, 1'b0, ok);
    phy_cycle();
    handshake(1'b0, 3, 5, 1, 5, 1, 0, ATO + 2, 1'b0, 1'b0, ok);
    handshake(1'b0, 3, 5, 1, 5, 1, 0, 1, 1'b1, 1'b0, ok);

    // PHY lost during SEND_ALIGN.
    phy_cycle();
    handshake(1'b0, 2, 7, 1, 7, 1, 0, 7, 1'b0, 1'b1, ok);

    // Randomized handshakes, at most one injected timeout each.
    for (int it = 0; it < 12; it++) begin
      int fault;
      phy_cycle();
      fault = int'($urandom_range(0, 5));
      if (fault > 3) fault = 0;
      rand_handshake(1'b0, fault, ok);
      if (!ok) rand_handshake(1'b0, 0, ok);
      if ($urandom_range(0, 1) == 1) begin
        rx_cominit = 1'b1;
        tick();
        check_val("rand_devreset_down", link_up, 1'b0);
        cominit_tail(int'($urandom_range(1, 3)));
        rand_handshake(1'b1, 0, ok);
      end
    end

    // Retry exhaustion with a silent device.
    phy_cycle();
    for (int k = 0; k < MAXR; k++) begin
      serve_req(0, 2);
      wait_phase(EV_CI, TO + 2, TO, ok);
    end
`ifdef SATA_OOB_RETRY_LIMIT_EN
    repeat (20) begin
      tick();
      check_val("locked_err", err, 1'b1);
      check_val("locked_no_comreset", tx_comreset, 1'b0);
      check_val("locked_elecidle", tx_elecidle, 1'b1);
    end
    phy_ready = 1'b0;
    repeat (3) tick();
    check_val("locked_ignores_phy", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_val("unlock_err", err, 1'b0);
    check_val("unlock_idle", tx_comreset, 1'b0);
`else
    serve_req(0, 2);
    check_val("retry_fourth_no_err", err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
